led_scanner: RTL and testbench
==============================

# led_scanner

Parametrised LED scanner for the iCE40 board LED bank. It moves a lit position across `N_LEDS` outputs at a programmable step rate. Four runtime modes are supported: bounce, wrap-up, wrap-down and bounce bar-graph. An optional fading trail can be compiled in. It sits between the board clock and the LED pins, and is driven by static configuration from top level or a register file.

## Interface
- `N_LEDS`, default 8: number of LED outputs, legal range 2..32.
- `DIV_W`, default 24: width of the step-period divider.
- `POS_W`, default `$clog2(N_LEDS)`: width of `pos`. Derived; do not override.
- `clki`, in, 1: system clock. All logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `enable`, in, 1: when 1 the scanner runs; when 0 it freezes.
- `mode`, in, 2: 0 = bounce, 1 = wrap-up, 2 = wrap-down, 3 = bar-graph bounce.
- `step_div`, in, `DIV_W`: step period minus one, in `clki` cycles.
- `leds`, out, `N_LEDS`: registered LED drive, active-high.
- `pos`, out, `POS_W`: current position, registered.
- `step`, out, 1: one-cycle pulse in the cycle `pos` and `leds` take a new value.

## Operation
- Reset values: `pos`=0, `dir`=up, divider count=0, `step`=0, `leds`=1 (bit 0 lit), trail state invalid.
- Divider:
  - When `enable`=1, the counter increments each cycle.
  - When count equals `step_div`, the counter clears and an internal tick is raised.
  - Tick period is `step_div`+1 cycles; `step_div`=0 gives a tick every cycle.
  - When `enable`=0, the counter, `pos`, `dir` and `leds` all hold, and `step` is 0.
- `step_div` is compared live. If it is lowered below the current count, the counter keeps counting and wraps through 2^`DIV_W` before the next tick. This is accepted behaviour and is not corrected.
- `mode` is sampled only on a tick. The next position is computed from the current `pos`, `dir` and the sampled `mode`:
  - Bounce (0, and 3):
    - If `dir`=up and `pos`=N_LEDS-1: `pos`←N_LEDS-2, `dir`←down.
    - If `dir`=down and `pos`=0: `pos`←1, `dir`←up.
    - Otherwise `pos`±1 according to `dir`.
    - End positions are displayed for exactly one step; no double dwell.
  - Wrap-up (1): `pos`←(`pos`+1) mod N_LEDS. `dir` is forced up.
  - Wrap-down (2): `pos`←(`pos`-1) mod N_LEDS. `dir` is forced down.
  - Arithmetic for non-power-of-two N_LEDS wraps explicitly at N_LEDS-1 and 0, not at 2^POS_W.
- `leds` is decoded from the new `pos` in the same register update, with no one-step lag:
  - Modes 0–2: one-hot, bit `pos` set.
  - Mode 3: thermometer, bits `pos`..0 set.
- Mode change mid-run: the current `pos` is retained and the next step follows the new mode from the current `pos` and `dir`. Example: switching 1→0 at `pos`=N-1 makes the next position N-2.
- Reset in any cycle, including on a tick or with `enable`=0, overrides everything and restores the reset values on the next edge.

## Timing
- A tick in cycle t updates `pos`, `leds` and `dir` at edge t+1. `step` is high during cycle t+1 only.
- First step after reset release with `enable`=1 occurs `step_div`+1 cycles after reset deasserts.
- Full bounce cycle for N LEDs is 2·(N−1) steps.
- Fmax target: 48 MHz on iCE40 UP5K with `DIV_W`=24.

## Configuration
- `LED_SCANNER_TRAIL_EN`:
  - Defined: the block keeps the two previous positions `prev1` and `prev2`, each with a valid bit; both are invalid after reset. On each step, `prev2`←`prev1` and `prev1`←old `pos`.
  - A free-running 2-bit `pwm` counter increments every cycle and is cleared by reset.
  - In modes 0–2, `leds` = one-hot(`pos`) OR (bit `prev1` if valid and `pwm`<2) OR (bit `prev2` if valid and `pwm`==0). This gives 100% / 50% / 25% brightness.
  - If a previous position equals `pos`, that bit stays fully on.
  - Mode 3 ignores the trail.
  - With the trail, `leds` may change on non-step cycles; `pos` and `step` timing are unchanged.
  - Undefined: no trail or PWM logic is built; `leds` behaves exactly as described in Operation.

## Test plan
- Reset, then N_LEDS=8, mode 0, `step_div`=0, `enable`=1 → `pos` sequence 0,1,…,7,6,…,0,1; `leds`=0x01,0x02,…,0x80,0x40; `step` high every cycle.
- N_LEDS=5, mode 1, `step_div`=3 → `pos` 1,2,3,4,0 at 4-cycle intervals. Then mode 2 → `pos` 4,3,2,1,0,4.
- Mode 3, N_LEDS=8 → `leds` 0x01,0x03,…,0xFF,0x7F,…,0x01.
- Toggle `enable` low for 10 cycles mid-count with `step_div`=5 → `pos`, `leds` and counter frozen; the next step arrives after the remaining count.
- Assert `reset` on a tick cycle at `pos`=6, `dir`=down → next edge `pos`=0, `leds`=0x01, `step`=0, `dir`=up.
- With `LED_SCANNER_TRAIL_EN` defined, mode 1, `pos`=3 after ≥2 steps → over 4 cycles, bit 3 is lit 4/4, bit 2 is lit 2/4, bit 1 is lit 1/4.

Source files
------------

// File: rtl/led_scanner.sv
// led_scanner: moves a lit position across N_LEDS outputs at a programmable
// step rate in bounce, wrap-up, wrap-down or bar-graph bounce mode.
// Optional fading trail of the two previous positions, compiled in by
// defining LED_SCANNER_TRAIL_EN (default build: no trail, no PWM logic).
module led_scanner #(
    parameter int unsigned N_LEDS = 8,
    parameter int unsigned DIV_W  = 24,
    parameter int unsigned POS_W  = $clog2(N_LEDS)
) (
    input  logic              clki,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [DIV_W-1:0]  step_div,
    output logic [N_LEDS-1:0] leds,
    output logic [POS_W-1:0]  pos,
    output logic              step
);

    localparam logic [1:0] MODE_BOUNCE  = 2'd0;
    localparam logic [1:0] MODE_WRAP_UP = 2'd1;
    localparam logic [1:0] MODE_WRAP_DN = 2'd2;
    localparam logic [1:0] MODE_BAR     = 2'd3;

    localparam logic [0:0] DIR_UP   = 1'b0;
    localparam logic [0:0] DIR_DOWN = 1'b1;

    localparam logic [POS_W-1:0] POS_ZERO = '0;
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_LEDS - 1);
    localparam logic [POS_W-1:0] POS_PREV = POS_W'(N_LEDS - 2);

    // One-hot decode of a position; loop keeps non-power-of-two widths in range.
    function automatic logic [N_LEDS-1:0] decode_onehot(input logic [POS_W-1:0] p);
        logic [N_LEDS-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < N_LEDS; i++) begin
            v[i] = (POS_W'(i) == p);
        end
        return v;
    endfunction

    // Thermometer decode: bits p..0 set.
    function automatic logic [N_LEDS-1:0] decode_therm(input logic [POS_W-1:0] p);
        logic [N_LEDS-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < N_LEDS; i++) begin
            v[i] = (POS_W'(i) <= p);
        end
        return v;
    endfunction

    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_cnt_next;
    logic              tick_c;
    logic [0:0]        dir;
    logic [0:0]        dir_next;
    logic [POS_W-1:0]  pos_next;
    logic              step_next;
    logic [N_LEDS-1:0] leds_next;

    // Step-period divider: live compare against step_div, tick on match.
    always_comb begin
        tick_c       = 1'b0;
        div_cnt_next = div_cnt;
        if (enable) begin
            if (div_cnt == step_div) begin
                tick_c       = 1'b1;
                div_cnt_next = '0;
            end else begin
                div_cnt_next = div_cnt + DIV_W'(1);
            end
        end
    end

    // Next position and direction; mode is only looked at on a tick.
    always_comb begin
        pos_next  = pos;
        dir_next  = dir;
        step_next = tick_c;
        if (tick_c) begin
            case (mode)
                MODE_WRAP_UP: begin
                    dir_next = DIR_UP;
                    pos_next = (pos == POS_LAST) ? POS_ZERO : pos + POS_ONE;
                end
                MODE_WRAP_DN: begin
                    dir_next = DIR_DOWN;
                    pos_next = (pos == POS_ZERO) ? POS_LAST : pos - POS_ONE;
                end
                MODE_BOUNCE, MODE_BAR: begin
                    if (dir == DIR_UP) begin
                        if (pos == POS_LAST) begin
                            pos_next = POS_PREV;
                            dir_next = DIR_DOWN;
                        end else begin
                            pos_next = pos + POS_ONE;
                        end
                    end else begin
                        if (pos == POS_ZERO) begin
                            pos_next = POS_ONE;
                            dir_next = DIR_UP;
                        end else begin
                            pos_next = pos - POS_ONE;
                        end
                    end
                end
                default: begin
                    pos_next = pos;
                    dir_next = dir;
                end
            endcase
        end
    end

`ifdef LED_SCANNER_TRAIL_EN
    logic [POS_W-1:0] prev1;
    logic [POS_W-1:0] prev2;
    logic [POS_W-1:0] prev1_next;
    logic [POS_W-1:0] prev2_next;
    logic             prev1_vld;
    logic             prev2_vld;
    logic             prev1_vld_next;
    logic             prev2_vld_next;
    logic [1:0]       pwm;
    logic [1:0]       pwm_next;
    logic             bar;
    logic             bar_next;

    // Trail history shifts on each step; PWM phase free-runs every cycle.
    always_comb begin
        prev1_next     = prev1;
        prev2_next     = prev2;
        prev1_vld_next = prev1_vld;
        prev2_vld_next = prev2_vld;
        bar_next       = bar;
        pwm_next       = pwm + 2'd1;
        if (tick_c) begin
            prev2_next     = prev1;
            prev2_vld_next = prev1_vld;
            prev1_next     = pos;
            prev1_vld_next = 1'b1;
            bar_next       = (mode == MODE_BAR);
        end
    end

    // LED drive: head at full, prev1 at 50%, prev2 at 25%; bar mode has no trail.
    always_comb begin
        leds_next = decode_onehot(pos_next);
        if (bar_next) begin
            leds_next = decode_therm(pos_next);
        end else begin
            if (prev1_vld_next && (pwm_next < 2'd2)) begin
                leds_next = leds_next | decode_onehot(prev1_next);
            end
            if (prev2_vld_next && (pwm_next == 2'd0)) begin
                leds_next = leds_next | decode_onehot(prev2_next);
            end
        end
    end

    // Trail state registers.
    always_ff @(posedge clki) begin
        if (reset) begin
            prev1     <= '0;
            prev2     <= '0;
            prev1_vld <= 1'b0;
            prev2_vld <= 1'b0;
            pwm       <= 2'd0;
            bar       <= 1'b0;
        end else begin
            prev1     <= prev1_next;
            prev2     <= prev2_next;
            prev1_vld <= prev1_vld_next;
            prev2_vld <= prev2_vld_next;
            pwm       <= pwm_next;
            bar       <= bar_next;
        end
    end
`else
    // LED drive decoded from the new position in the same update as pos.
    always_comb begin
        leds_next = leds;
        if (tick_c) begin
            if (mode == MODE_BAR) begin
                leds_next = decode_therm(pos_next);
            end else begin
                leds_next = decode_onehot(pos_next);
            end
        end
    end
`endif

    // Scanner state and registered outputs.
    always_ff @(posedge clki) begin
        if (reset) begin
            div_cnt <= '0;
            pos     <= '0;
            dir     <= DIR_UP;
            step    <= 1'b0;
            leds    <= N_LEDS'(1);
        end else begin
            div_cnt <= div_cnt_next;
            pos     <= pos_next;
            dir     <= dir_next;
            step    <= step_next;
            leds    <= leds_next;
        end
    end

endmodule

// File: tb/tb_led_scanner.sv
// tb_led_scanner: directed checks of led_scanner with N_LEDS=8 and N_LEDS=5.
// Trail checks are included when LED_SCANNER_TRAIL_EN is defined.
module tb_led_scanner;

    localparam int unsigned DIV_W = 24;

    logic             clk;
    logic             rst8;
    logic             en8;
    logic [1:0]       mode8;
    logic [DIV_W-1:0] div8;
    logic [7:0]       leds8;
    logic [2:0]       pos8;
    logic             step8;

    logic             rst5;
    logic             en5;
    logic [1:0]       mode5;
    logic [DIV_W-1:0] div5;
    logic [4:0]       leds5;
    logic [2:0]       pos5;
    logic             step5;

    int n_checks;
    int n_errors;

    int unsigned bounce_seq [16] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
    int unsigned bar_seq    [14] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0};
    int unsigned up5_seq    [5]  = '{1, 2, 3, 4, 0};
    int unsigned dn5_seq    [6]  = '{4, 3, 2, 1, 0, 4};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    led_scanner #(.N_LEDS(8), .DIV_W(DIV_W)) dut8 (
        .clki     (clk),
        .reset    (rst8),
        .enable   (en8),
        .mode     (mode8),
        .step_div (div8),
        .leds     (leds8),
        .pos      (pos8),
        .step     (step8)
    );

    led_scanner #(.N_LEDS(5), .DIV_W(DIV_W)) dut5 (
        .clki     (clk),
        .reset    (rst5),
        .enable   (en5),
        .mode     (mode5),
        .step_div (div5),
        .leds     (leds5),
        .pos      (pos5),
        .step     (step5)
    );

    task automatic step_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Position bit must be lit; without the trail the whole vector is one-hot.
    task automatic check_onehot(input string tag, input logic [31:0] obs, input int unsigned p);
`ifdef LED_SCANNER_TRAIL_EN
        check(tag, 32'(obs[p]), 32'd1);
`else
        check(tag, obs, 32'd1 << p);
`endif
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst8 = 1'b1; en8 = 1'b0; mode8 = 2'd0; div8 = '0;
        rst5 = 1'b1; en5 = 1'b0; mode5 = 2'd0; div5 = '0;
        step_clk(3);

        // Reset state
        check("rst8_pos", 32'(pos8), 32'd0);
        check("rst8_leds", 32'(leds8), 32'h01);
        check("rst8_step", 32'(step8), 32'd0);
        check("rst5_pos", 32'(pos5), 32'd0);
        check("rst5_leds", 32'(leds5), 32'h01);

        // Bounce, step every cycle
        rst8 = 1'b0; en8 = 1'b1; mode8 = 2'd0; div8 = '0;
        for (int i = 0; i < 16; i++) begin
            step_clk(1);
            check($sformatf("bounce_pos[%0d]", i), 32'(pos8), bounce_seq[i]);
            check_onehot($sformatf("bounce_leds[%0d]", i), 32'(leds8), bounce_seq[i]);
            check($sformatf("bounce_step[%0d]", i), 32'(step8), 32'd1);
        end

        // Bar-graph bounce from reset
        rst8 = 1'b1;
        step_clk(1);
        check("bar_rst_pos", 32'(pos8), 32'd0);
        check("bar_rst_leds", 32'(leds8), 32'h01);
        check("bar_rst_step", 32'(step8), 32'd0);
        rst8 = 1'b0; mode8 = 2'd3;
        for (int i = 0; i < 14; i++) begin
            step_clk(1);
            check($sformatf("bar_leds[%0d]", i), 32'(leds8), (32'd1 << (bar_seq[i] + 1)) - 32'd1);
        end

        // Wrap-up to the top, then switch to bounce: next position is N-2
        mode8 = 2'd1;
        for (int i = 1; i <= 7; i++) begin
            step_clk(1);
            check($sformatf("wrap8_pos[%0d]", i), 32'(pos8), 32'(i));
        end
        mode8 = 2'd0;
        step_clk(1);
        check("switch_pos", 32'(pos8), 32'd6);

        // Reset on a tick cycle at pos 6 going down
        rst8 = 1'b1;
        step_clk(1);
        check("tickrst_pos", 32'(pos8), 32'd0);
        check("tickrst_leds", 32'(leds8), 32'h01);
        check("tickrst_step", 32'(step8), 32'd0);
        rst8 = 1'b0;
        step_clk(1);
        check("tickrst_up1", 32'(pos8), 32'd1);
        step_clk(1);
        check("tickrst_up2", 32'(pos8), 32'd2);

        // Enable freeze with step_div = 5
        rst8 = 1'b1; div8 = DIV_W'(5); mode8 = 2'd0;
        step_clk(1);
        rst8 = 1'b0; en8 = 1'b1;
        step_clk(5);
        check("first_step_pre_pos", 32'(pos8), 32'd0);
        check("first_step_pre_step", 32'(step8), 32'd0);
        step_clk(1);
        check("first_step_pos", 32'(pos8), 32'd1);
        check("first_step_step", 32'(step8), 32'd1);
        step_clk(2);
        check("pre_freeze_step", 32'(step8), 32'd0);
        en8 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step_clk(1);
            check($sformatf("freeze_pos[%0d]", i), 32'(pos8), 32'd1);
            check($sformatf("freeze_step[%0d]", i), 32'(step8), 32'd0);
        end
        check_onehot("freeze_leds", 32'(leds8), 1);
        en8 = 1'b1;
        step_clk(3);
        check("resume_pre_pos", 32'(pos8), 32'd1);
        check("resume_pre_step", 32'(step8), 32'd0);
        step_clk(1);
        check("resume_pos", 32'(pos8), 32'd2);
        check("resume_step", 32'(step8), 32'd1);

        // N_LEDS=5: wrap-up then wrap-down at 4-cycle intervals
        rst5 = 1'b0; en5 = 1'b1; mode5 = 2'd1; div5 = DIV_W'(3);
        for (int i = 0; i < 5; i++) begin
            step_clk(3);
            check($sformatf("up5_hold_step[%0d]", i), 32'(step5), 32'd0);
            step_clk(1);
            check($sformatf("up5_pos[%0d]", i), 32'(pos5), up5_seq[i]);
            check($sformatf("up5_step[%0d]", i), 32'(step5), 32'd1);
            check_onehot($sformatf("up5_leds[%0d]", i), 32'(leds5), up5_seq[i]);
        end
        mode5 = 2'd2;
        for (int i = 0; i < 6; i++) begin
            step_clk(4);
            check($sformatf("dn5_pos[%0d]", i), 32'(pos5), dn5_seq[i]);
            check_onehot($sformatf("dn5_leds[%0d]", i), 32'(leds5), dn5_seq[i]);
        end

`ifdef LED_SCANNER_TRAIL_EN
        // Trail brightness at pos 3 after steps 1, 2, 3
        begin
            int c3;
            int c2;
            int c1;
            c3 = 0; c2 = 0; c1 = 0;
            rst8 = 1'b1; en8 = 1'b1; mode8 = 2'd1; div8 = DIV_W'(3);
            step_clk(1);
            rst8 = 1'b0;
            step_clk(12);
            check("trail_pos", 32'(pos8), 32'd3);
            for (int i = 0; i < 4; i++) begin
                if (i > 0) step_clk(1);
                c3 += int'(leds8[3]);
                c2 += int'(leds8[2]);
                c1 += int'(leds8[1]);
            end
            check("trail_bit3", 32'(c3), 32'd4);
            check("trail_bit2", 32'(c2), 32'd2);
            check("trail_bit1", 32'(c1), 32'd1);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
